// File: rtl/sram_boot_loader.sv
// Byte-stream boot loader: packs bytes little-endian into 32-bit words, writes them to SRAM port 0
// and holds the core in reset until the image is in. Define SRAM_LOADER_VERIFY_EN for port-1 readback checking.
module sram_boot_loader #(
    parameter int ADDR_WIDTH = 9,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_WORDS  = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  restart,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [3:0]            sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [31:0]           sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [31:0]           sram_dout1,
    output logic                  cpu_hold,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_loaded
`ifdef SRAM_LOADER_VERIFY_EN
    ,
    output logic                  mismatch,
    output logic [ADDR_WIDTH-1:0] mismatch_addr
`endif
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   MAXW = (ADDR_WIDTH+1)'(MAX_WORDS);

    typedef enum logic [2:0] {S_COLLECT, S_WRITE, S_RDBACK, S_CMP, S_DONE} state_t;

    state_t                state;
    logic [1:0]            byte_idx;
    logic [31:0]           word;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  last_seen;
    logic                  accept;
    logic [31:0]           merged;
    logic [ADDR_WIDTH:0]   wl_next;

    assign accept  = in_valid && in_ready;
    assign wl_next = words_loaded + 1'b1;

    // A new word starts from zero so a short final word has clean upper bytes.
    always_comb begin
        merged = (byte_idx == 2'd0) ? 32'h0 : word;
        merged[{byte_idx, 3'b000} +: 8] = in_data;
    end

`ifndef SRAM_LOADER_VERIFY_EN
    logic unused_dout1;
    assign unused_dout1 = ^sram_dout1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_COLLECT;
            byte_idx     <= 2'd0;
            word         <= 32'h0;
            wr_addr      <= BASE;
            last_seen    <= 1'b0;
            in_ready     <= 1'b0;
            sram_csb0    <= 1'b1;
            sram_web0    <= 1'b1;
            sram_wmask0  <= 4'h0;
            sram_addr0   <= BASE;
            sram_din0    <= 32'h0;
            sram_csb1    <= 1'b1;
            sram_addr1   <= BASE;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            words_loaded <= '0;
`ifdef SRAM_LOADER_VERIFY_EN
            mismatch      <= 1'b0;
            mismatch_addr <= '0;
`endif
        end else begin
            case (state)
                S_COLLECT: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        word     <= merged;
                        byte_idx <= 2'(byte_idx + 2'd1);
                        if (in_last && byte_idx == 2'd0) begin
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (in_last || byte_idx == 2'd3) begin
                            state       <= S_WRITE;
                            in_ready    <= 1'b0;
                            last_seen   <= in_last;
                            sram_csb0   <= 1'b0;
                            sram_web0   <= 1'b0;
                            sram_wmask0 <= 4'hF;
                            sram_addr0  <= wr_addr;
                            sram_din0   <= merged;
                        end
                    end
                end
                S_WRITE: begin
                    sram_csb0    <= 1'b1;
                    sram_web0    <= 1'b1;
                    sram_wmask0  <= 4'h0;
                    wr_addr      <= ADDR_WIDTH'(wr_addr + 1'b1);
                    words_loaded <= wl_next;
                    byte_idx     <= 2'd0;
`ifdef SRAM_LOADER_VERIFY_EN
                    state      <= S_RDBACK;
                    sram_csb1  <= 1'b0;
                    sram_addr1 <= wr_addr;
`else
                    if (last_seen || wl_next == MAXW) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state    <= S_COLLECT;
                        in_ready <= 1'b1;
                    end
`endif
                end
`ifdef SRAM_LOADER_VERIFY_EN
                // Read is latched at the end of RDBACK; data settles after the CMP-cycle negedge.
                S_RDBACK: begin
                    sram_csb1 <= 1'b1;
                    state     <= S_CMP;
                end
                S_CMP: begin
                    if (sram_dout1 != word) begin
                        mismatch <= 1'b1;
                        if (!mismatch) mismatch_addr <= sram_addr1;
                    end
                    if (last_seen || words_loaded == MAXW) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state    <= S_COLLECT;
                        in_ready <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    in_ready <= 1'b0;
                    if (restart) begin
                        state        <= S_COLLECT;
                        in_ready     <= 1'b1;
                        wr_addr      <= BASE;
                        words_loaded <= '0;
                        byte_idx     <= 2'd0;
                        last_seen    <= 1'b0;
                        done         <= 1'b0;
                        cpu_hold     <= 1'b1;
`ifdef SRAM_LOADER_VERIFY_EN
                        mismatch     <= 1'b0;
`endif
                    end
                end
                default: state <= S_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_boot_loader.sv
// Bench for sram_boot_loader (MAX_WORDS=4) with a behavioural 1rw1r SRAM model.
module tb_sram_boot_loader;

    localparam logic [31:0] SENT = 32'hDEADBEEF;

    logic        clk, rst;
    logic        in_valid, in_last, in_ready, restart;
    logic [7:0]  in_data;
    logic        sram_csb0, sram_web0, sram_csb1;
    logic [3:0]  sram_wmask0;
    logic [8:0]  sram_addr0, sram_addr1;
    logic [31:0] sram_din0, sram_dout1;
    logic        cpu_hold, done;
    logic [9:0]  words_loaded;
`ifdef SRAM_LOADER_VERIFY_EN
    logic        mismatch;
    logic [8:0]  mismatch_addr;
`endif

    sram_boot_loader #(.ADDR_WIDTH(9), .BASE_ADDR(0), .MAX_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .restart(restart),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1),
        .cpu_hold(cpu_hold), .done(done), .words_loaded(words_loaded)
`ifdef SRAM_LOADER_VERIFY_EN
        , .mismatch(mismatch), .mismatch_addr(mismatch_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: inputs latched at posedge, operation at negedge, read data after a hold delay.
    logic [31:0] mem [0:511];
    logic        m_csb0 = 1'b1, m_web0 = 1'b1, m_csb1 = 1'b1;
    logic [3:0]  m_wmask;
    logic [8:0]  m_addr0, m_addr1;
    logic [31:0] m_din0;
    int          writes_seen = 0;
    logic [3:0]  last_wmask = 4'h0;
    int          clr_req, clr_ack = 0;
    logic        flip_en;
    logic [8:0]  flip_addr;

    always @(posedge clk) begin
        m_csb0  <= sram_csb0;   m_web0  <= sram_web0; m_wmask <= sram_wmask0;
        m_addr0 <= sram_addr0;  m_din0  <= sram_din0;
        m_csb1  <= sram_csb1;   m_addr1 <= sram_addr1;
    end

    always @(negedge clk) begin
        if (clr_req != clr_ack) begin
            for (int a = 0; a < 8; a++) mem[a] <= SENT;
            clr_ack <= clr_req;
        end else if (!m_csb0 && !m_web0) begin
            for (int b = 0; b < 4; b++)
                if (m_wmask[b]) mem[m_addr0][8*b +: 8] <= m_din0[8*b +: 8];
            writes_seen <= writes_seen + 1;
            last_wmask  <= m_wmask;
        end
    end

    always @(negedge clk) begin
        if (!m_csb1) begin
            #1;
            sram_dout1 <= mem[m_addr1] ^ ((flip_en && m_addr1 == flip_addr) ? 32'h1 : 32'h0);
        end
    end

    int total = 0, bad = 0;
    logic [7:0]  txq [$];
    logic [31:0] expw [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Offers every byte of txq; a byte is taken at the posedge following a negedge where in_ready=1.
    task automatic send(input bit use_last, input int gap_mode, input int wait_max, output int acc);
        acc = 0;
        for (int i = 0; i < txq.size(); i++) begin
            int g;
            bit got;
            g = (gap_mode == 1 && i > 0) ? 1 : (gap_mode == 2 ? int'($urandom_range(0, 2)) : 0);
            in_valid = 1'b0;
            in_last  = 1'b0;
            repeat (g) @(negedge clk);
            in_valid = 1'b1;
            in_data  = txq[i];
            in_last  = use_last && (i == txq.size() - 1);
            got = 1'b0;
            for (int w = 0; w < wait_max && !got; w++) begin
                got = in_ready;
                @(negedge clk);
            end
            if (got) acc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic clear_mem;
        clr_req++;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_restart;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("rs_done", done, 1'b0);
        chk("rs_hold", cpu_hold, 1'b1);
        chk("rs_wl", words_loaded, 0);
        chk("rs_rdy", in_ready, 1'b1);
    endtask

    task automatic check_image(input string tag, input int nw, input int wbase, input bit tail);
        int n;
        n = 0;
        while (!done && n < 40) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_hold"}, cpu_hold, 1'b0);
        chk({tag, "_wl"}, words_loaded, nw);
        chk({tag, "_nwr"}, writes_seen - wbase, nw);
        chk({tag, "_rdy"}, in_ready, 1'b0);
        for (int k = 0; k < nw; k++) chk({tag, "_mem"}, mem[k], expw[k]);
        if (tail && nw < 8) chk({tag, "_tail"}, mem[nw], SENT);
        if (nw > 0) chk({tag, "_mask"}, last_wmask, 4'hF);
`ifdef SRAM_LOADER_VERIFY_EN
        chk({tag, "_mis"}, mismatch, 1'b0);
`endif
    endtask

    // Reference: bytes fill words little-endian; at most 4 words (16 bytes) are accepted.
    function automatic int model(input int accepted);
        for (int k = 0; k < 8; k++) expw[k] = 32'h0;
        for (int i = 0; i < accepted; i++) expw[i / 4][(i % 4) * 8 +: 8] = txq[i];
        return ((accepted + 3) / 4 > 4) ? 4 : (accepted + 3) / 4;
    endfunction

    typedef struct {
        int          n;
        logic [63:0] bytes;
        int          gap;
        int          nw;
        logic [31:0] w0, w1;
    } vec_t;
    vec_t vt [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc, wb, nw, len, exp_acc;
        vt[0] = '{4, 64'h00000000FA010113, 0, 1, 32'hFA010113, 32'h0};
        vt[1] = '{2, 64'h000000000000BBAA, 0, 1, 32'h0000BBAA, 32'h0};
        vt[2] = '{8, 64'h8877665544332211, 1, 2, 32'h44332211, 32'h88776655};
        vt[3] = '{6, 64'h0000060504030201, 0, 2, 32'h04030201, 32'h00000605};
        vt[4] = '{7, 64'h00F6F5F4F3F2F1F0, 1, 2, 32'hF3F2F1F0, 32'h00F6F5F4};
        vt[5] = '{3, 64'h0000000000BEADDE, 0, 1, 32'h00BEADDE, 32'h0};

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h0; restart = 1'b0;
        flip_en = 1'b0; flip_addr = 9'd0; clr_req = 0;
        clear_mem;
        @(negedge clk);
        chk("rst_rdy", in_ready, 1'b0);
        chk("rst_csb0", sram_csb0, 1'b1);
        chk("rst_web0", sram_web0, 1'b1);
        chk("rst_wmask", sram_wmask0, 4'h0);
        chk("rst_addr0", sram_addr0, 9'd0);
        chk("rst_din0", sram_din0, 32'h0);
        chk("rst_csb1", sram_csb1, 1'b1);
        chk("rst_addr1", sram_addr1, 9'd0);
        chk("rst_hold", cpu_hold, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_wl", words_loaded, 0);
`ifdef SRAM_LOADER_VERIFY_EN
        chk("rst_mis", mismatch, 1'b0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", in_ready, 1'b1);

        // First write one cycle after the 4th byte, with last on that byte.
        wb = writes_seen;
        txq = '{8'h13, 8'h01, 8'h01};
        send(1'b0, 0, 8, acc);
        in_valid = 1'b1; in_data = 8'hFA; in_last = 1'b1;
        chk("lat_rdy", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("lat_csb0", sram_csb0, 1'b0);
        chk("lat_web0", sram_web0, 1'b0);
        chk("lat_wmask", sram_wmask0, 4'hF);
        chk("lat_addr0", sram_addr0, 9'd0);
        chk("lat_din0", sram_din0, 32'hFA010113);
        chk("lat_rdy_lo", in_ready, 1'b0);
        expw[0] = 32'hFA010113;
        check_image("lat", 1, wb, 1'b1);

        for (int v = 0; v < 6; v++) begin
            clear_mem;
            do_restart;
            txq.delete();
            for (int i = 0; i < vt[v].n; i++) txq.push_back(vt[v].bytes[8*i +: 8]);
            wb = writes_seen;
            send(1'b1, vt[v].gap, 8, acc);
            chk("vec_acc", acc, vt[v].n);
            expw[0] = vt[v].w0;
            expw[1] = vt[v].w1;
            check_image("vec", vt[v].nw, wb, 1'b1);
        end

        // 20 bytes against a 4-word limit: 16 taken, the rest refused, no 5th write.
        clear_mem;
        do_restart;
        txq.delete();
        for (int i = 0; i < 20; i++) txq.push_back(8'($urandom));
        wb = writes_seen;
        send(1'b1, 0, 8, acc);
        chk("max_acc", acc, 16);
        nw = model(16);
        check_image("max", nw, wb, 1'b1);

        // restart while collecting is ignored.
        clear_mem;
        do_restart;
        txq = '{8'h01, 8'h02, 8'h03, 8'h04};
        wb = writes_seen;
        send(1'b0, 0, 8, acc);
        for (int n = 0; n < 20 && words_loaded != 1; n++) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("rsi_wl", words_loaded, 1);
        chk("rsi_done", done, 1'b0);
        txq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        nw = model(8);
        txq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send(1'b1, 0, 8, acc);
        check_image("rsi", nw, wb, 1'b1);

        // rst during the WRITE of word 2, then a fresh 4-byte load.
        clear_mem;
        do_restart;
        txq = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70};
        send(1'b0, 0, 8, acc);
        in_valid = 1'b1; in_data = 8'h80;
        for (int n = 0; n < 8 && !in_ready; n++) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mrst_wr", sram_csb0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mrst_csb0", sram_csb0, 1'b1);
        chk("mrst_web0", sram_web0, 1'b1);
        chk("mrst_wl", words_loaded, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_rdy", in_ready, 1'b1);
        txq = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
        wb = writes_seen;
        send(1'b1, 0, 8, acc);
        expw[0] = 32'h8D7C6B5A;
        check_image("mrst", 1, wb, 1'b0);

        // Randomized images with random gaps (lengths avoiding a lone trailing byte).
        for (int r = 0; r < 12; r++) begin
            clear_mem;
            do_restart;
            do len = int'($urandom_range(2, 20)); while (len % 4 == 1 && len <= 16);
            txq.delete();
            for (int i = 0; i < len; i++) txq.push_back(8'($urandom));
            exp_acc = (len > 16) ? 16 : len;
            nw = model(exp_acc);
            wb = writes_seen;
            send(1'b1, 2, 8, acc);
            chk("rnd_acc", acc, exp_acc);
            check_image("rnd", nw, wb, 1'b1);
        end

`ifdef SRAM_LOADER_VERIFY_EN
        clear_mem;
        do_restart;
        flip_en = 1'b1; flip_addr = 9'd2;
        txq.delete();
        for (int i = 0; i < 16; i++) txq.push_back(8'(i * 7 + 3));
        send(1'b1, 0, 8, acc);
        for (int n = 0; n < 40 && !done; n++) @(negedge clk);
        chk("ver_done", done, 1'b1);
        chk("ver_mis", mismatch, 1'b1);
        chk("ver_maddr", mismatch_addr, 9'd2);
        flip_en = 1'b0;
        do_restart;
        chk("ver_clr", mismatch, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
